adc_decim: RTL

- Sits directly downstream of adc_sim, clocked by the same clk as the ADC (adc_clk = clk).
- Takes one ADC code per cycle and converts it to signed.
- Sums 2^LOG2_DEC consecutive samples into a full-precision, boxcar-decimated result.
- Presents each result on a valid/ready output with a per-window overflow flag. Feeds downstream measurement/logging of the RLC current.

---
 rtl/adc_decim_pkg.sv | 29 ++
 rtl/adc_decim_acc.sv | 63 ++++++
 rtl/adc_decim.sv | 139 +++++++++++++
 3 files changed

// File: rtl/adc_decim_pkg.sv
// adc_decim_pkg: shared types and helpers for the ADC boxcar decimator.
//   state_t   : decimator FSM states (IDLE / ACC)
//   win_len   : number of samples per output window for a given LOG2_DEC
//   to_signed : converts a raw ADC code to a sign-extended two's-complement sample
package adc_decim_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    ACC  = 1'b1
  } state_t;

  localparam int DEF_LOG2_DEC = 4;

  function automatic int unsigned win_len(input int unsigned log2_dec);
    return 32'd1 << log2_dec;
  endfunction

  // Offset-binary codes become two's complement by flipping the MSB; the
  // shift pair then sign-extends from bit (bits-1) up to 32 bits.
  function automatic logic signed [31:0] to_signed(input logic [31:0] code,
                                                   input int unsigned bits,
                                                   input bit is_signed);
    logic [31:0] raw;
    raw = code;
    if (!is_signed) raw[bits-1] = ~raw[bits-1];
    return $signed(raw << (32 - bits)) >>> (32 - bits);
  endfunction

endpackage

// File: rtl/adc_decim_acc.sv
// adc_decim_acc: window accumulator for the boxcar decimator.
//   clk, rst_n  : clock, asynchronous active-low reset
//   run         : accumulate the current sample; low clears the partial window
//   sample      : sign-extended sample (W bits)
//   flag        : overflow flag of the current sample
//   last        : current sample is the last one of the window
//   sum         : window sum including the current sample (valid with last)
//   wovfl_final : window overflow including the current sample (valid with last)
module adc_decim_acc
  import adc_decim_pkg::*;
#(
  parameter int W        = 12,
  parameter int LOG2_DEC = DEF_LOG2_DEC
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                run,
  input  logic signed [W-1:0] sample,
  input  logic                flag,
  output logic                last,
  output logic signed [W-1:0] sum,
  output logic                wovfl_final
);

  localparam logic [LOG2_DEC-1:0] CNT_LAST = LOG2_DEC'(win_len(LOG2_DEC) - 1);

  logic signed [W-1:0] acc_q, acc_d;
  logic [LOG2_DEC-1:0] cnt_q, cnt_d;
  logic                wovfl_q, wovfl_d;

  // On the last sample the window restarts from zero on the same edge so
  // consecutive windows follow each other with no gap.
  always_comb begin
    last        = run && (cnt_q == CNT_LAST);
    sum         = acc_q + sample;
    wovfl_final = wovfl_q | flag;
    acc_d       = acc_q;
    cnt_d       = cnt_q;
    wovfl_d     = wovfl_q;
    if (!run || last) begin
      acc_d   = '0;
      cnt_d   = '0;
      wovfl_d = 1'b0;
    end else begin
      acc_d   = sum;
      cnt_d   = cnt_q + 1'b1;
      wovfl_d = wovfl_final;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q   <= '0;
      cnt_q   <= '0;
      wovfl_q <= 1'b0;
    end else begin
      acc_q   <= acc_d;
      cnt_q   <= cnt_d;
      wovfl_q <= wovfl_d;
    end
  end

endmodule

// File: rtl/adc_decim.sv
// adc_decim: boxcar decimator for ADC codes with valid/ready output.
// Sums 2^LOG2_DEC consecutive samples into a full-precision signed result.
//   clk, rst_n         : sample clock, asynchronous active-low reset
//   en                 : high = accumulate continuous windows
//   code               : ADC code (BITS)
//   ovfl_pos/ovfl_neg  : ADC overflow flags for this code
//   clr                : synchronous clear of drop
//   dat, ovfl, val     : window sum, window overflow, output valid
//   rdy                : downstream ready
//   drop               : sticky, a completed window was lost
// Build option ADC_DECIM_OVFL_DISCARD_EN: windows containing an overflowed
// sample are silently discarded and ovfl is tied to 0.
module adc_decim
  import adc_decim_pkg::*;
#(
  parameter int    BITS     = 8,
  parameter string TYPE     = "unsigned",
  parameter int    LOG2_DEC = DEF_LOG2_DEC
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         en,
  input  logic [BITS-1:0]              code,
  input  logic                         ovfl_pos,
  input  logic                         ovfl_neg,
  input  logic                         clr,
  output logic signed [BITS+LOG2_DEC-1:0] dat,
  output logic                         ovfl,
  output logic                         val,
  input  logic                         rdy,
  output logic                         drop
);

  localparam int W         = BITS + LOG2_DEC;
  localparam bit IS_SIGNED = (TYPE == "signed");

  state_t              state_q, state_d;
  logic                run;
  logic signed [W-1:0] sample;
  logic                last;
  logic signed [W-1:0] sum;
  logic                wovfl_final;
  logic                accept;
  logic                load;
  logic                lost;

  logic signed [W-1:0] dat_q, dat_d;
  logic                val_q, val_d;
  logic                drop_q, drop_d;

  assign sample = W'(to_signed(32'(code), BITS, IS_SIGNED));

  // Dropping en in ACC discards the partial window on that same edge.
  assign run = (state_q == ACC) && en;

  adc_decim_acc #(
    .W        (W),
    .LOG2_DEC (LOG2_DEC)
  ) u_acc (
    .clk         (clk),
    .rst_n       (rst_n),
    .run         (run),
    .sample      (sample),
    .flag        (ovfl_pos | ovfl_neg),
    .last        (last),
    .sum         (sum),
    .wovfl_final (wovfl_final)
  );

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (en)  state_d = ACC;
      ACC:     if (!en) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

`ifdef ADC_DECIM_OVFL_DISCARD_EN
  assign accept = last && !wovfl_final;
  assign ovfl   = 1'b0;
`else
  assign accept = last;
`endif

  // A completed window loads if the output slot is free or is being emptied
  // on this same edge; otherwise it is lost and flagged.
  assign load = accept && (!val_q || rdy);
  assign lost = accept && val_q && !rdy;

  always_comb begin
    dat_d  = dat_q;
    val_d  = val_q;
    drop_d = drop_q;
    if (load) begin
      dat_d = sum;
      val_d = 1'b1;
    end else if (val_q && rdy) begin
      val_d = 1'b0;
    end
    if (lost)     drop_d = 1'b1;
    else if (clr) drop_d = 1'b0;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      dat_q   <= '0;
      val_q   <= 1'b0;
      drop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      dat_q   <= dat_d;
      val_q   <= val_d;
      drop_q  <= drop_d;
    end
  end

`ifndef ADC_DECIM_OVFL_DISCARD_EN
  logic ovfl_q, ovfl_d;

  always_comb begin
    ovfl_d = ovfl_q;
    if (load) ovfl_d = wovfl_final;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ovfl_q <= 1'b0;
    else        ovfl_q <= ovfl_d;
  end

  assign ovfl = ovfl_q;
`endif

  assign dat  = dat_q;
  assign val  = val_q;
  assign drop = drop_q;

endmodule
